count_bcd_display: RTL and testbench

Display back-end for the counter design. Samples the 8-bit count produced by the counter stage and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto one 7-segment display with leading-zero blanking. It sits directly downstream of the counter and drives the dedicated output pins.

---
 rtl/count_bcd_display_if.sv | 20 ++
 rtl/count_bcd_display.sv | 152 +++++++++++++++
 tb/tb_count_bcd_display.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_bcd_display_if.sv
// Display back-end bus: counter-side inputs and display pin outputs.
// The counter drives ena/value; the display block drives the pins.
interface count_bcd_display_if;
    logic       ena;
    logic [7:0] value;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] digit_sel;
    logic       busy;

    modport master (
        output ena, value,
        input  seg, dp, digit_sel, busy
    );

    modport slave (
        input  ena, value,
        output seg, dp, digit_sel, busy
    );
endinterface

// File: rtl/count_bcd_display.sv
// Binary-to-BCD display back-end: sequential double-dabble conversion,
// then a time-multiplexed 7-segment drive with leading-zero blanking.
module count_bcd_display #(
    parameter int unsigned REFRESH_DIV   = 1024,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    count_bcd_display_if.slave bus
);
    localparam int unsigned   PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

    state_e        state_q, state_d;
    logic [7:0]    last_q, last_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [19:0]   shift_q, shift_d;
    logic [19:0]   adj;
    logic [2:0]    iter_q, iter_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [2:0]    sel_q, sel_d;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        adj     = {add3(shift_q[19:16]), add3(shift_q[15:12]),
                   add3(shift_q[11:8]), shift_q[7:0]};
        unique case (state_q)
            IDLE: begin
                if (bus.ena && bus.value != last_q) begin
                    last_d  = bus.value;
                    shift_d = {12'd0, bus.value};
                    iter_d  = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {adj[18:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) state_d = LOAD;
            end
            LOAD: begin
                // digits only ever change here, never mid-conversion
                {hund_d, tens_d, ones_d} = shift_q[19:8];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_comb begin
        digit = ones_q;
        blank = 1'b0;
        unique case (idx_q)
            2'd0: begin
                digit = ones_q;
                blank = 1'b0;
            end
            2'd1: begin
                digit = tens_q;
                blank = BLANK_LEADING && hund_q == 4'd0 && tens_q == 4'd0;
            end
            default: begin
                digit = hund_q;
                blank = BLANK_LEADING && hund_q == 4'd0;
            end
        endcase
        seg_d = blank ? 7'h00 : pat(digit);
        sel_d = 3'b001 << idx_q;
        dp_d  = (idx_q == 2'd0) && !bus.ena;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            shift_q <= '0;
            iter_q  <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h3F;
            dp_q    <= 1'b0;
            sel_q   <= 3'b001;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_sel = sel_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: arithmetic reference model plus
// directed literal checks on conversion, blanking, pause and refresh.
module tb_count_bcd_display;
    localparam int RD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic [7:0] value = 8'd0;
    bit         chk_en = 1'b0;
    int         total = 0;
    int         bad   = 0;

    count_bcd_display_if b1();
    count_bcd_display_if b2();

    assign b1.ena   = ena;
    assign b1.value = value;
    assign b2.ena   = ena;
    assign b2.value = value;

    count_bcd_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    count_bcd_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nedge;
        int         cnt;
        int         mlast;
        int         mdisp;
        logic [6:0] seg1;
        logic [6:0] seg2;
        logic [2:0] sel;
        logic       dp;
    } model_t;

    function automatic model_t mreset();
        model_t r;
        r.nedge = 0; r.cnt = 0; r.mlast = 0; r.mdisp = 0;
        r.seg1 = 7'h3F; r.seg2 = 7'h3F; r.sel = 3'b001; r.dp = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    // What a given digit position must show for a displayed number.
    function automatic logic [6:0] exp_seg(input int v, input int pos,
                                           input bit blank);
        if (pos == 0) return pat(v % 10);
        if (pos == 1) return (blank && v < 10) ? 7'h00 : pat((v / 10) % 10);
        return (blank && v < 100) ? 7'h00 : pat(v / 100);
    endfunction

    // One clock edge: outputs from pre-edge state, then a conversion
    // takes 9 busy cycles and lands the new number at its last edge.
    function automatic model_t step(input model_t c, input bit en,
                                    input int v);
        model_t n;
        int pos;
        n = c;
        pos = (c.nedge / RD) % 3;
        n.sel  = 3'(1 << pos);
        n.seg1 = exp_seg(c.mdisp, pos, 1'b1);
        n.seg2 = exp_seg(c.mdisp, pos, 1'b0);
        n.dp   = (pos == 0) && !en;
        n.nedge = c.nedge + 1;
        if (c.cnt == 0) begin
            if (en && v != c.mlast) begin
                n.mlast = v;
                n.cnt   = 9;
            end
        end else begin
            n.cnt = c.cnt - 1;
            if (n.cnt == 0) n.mdisp = c.mlast;
        end
        return n;
    endfunction

    model_t m = '{0, 0, 0, 0, 7'h3F, 7'h3F, 3'b001, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mreset();
        else        m <= step(m, ena, int'(value));
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("m_seg1", 32'(b1.seg), 32'(m.seg1));
            check("m_seg2", 32'(b2.seg), 32'(m.seg2));
            check("m_sel1", 32'(b1.digit_sel), 32'(m.sel));
            check("m_sel2", 32'(b2.digit_sel), 32'(m.sel));
            check("m_dp", 32'(b1.dp), 32'(m.dp));
            check("m_busy1", 32'(b1.busy), 32'(m.cnt != 0));
            check("m_busy2", 32'(b2.busy), 32'(m.cnt != 0));
        end
    end

    task automatic conv_wait(input string nm);
        int n;
        n = 0;
        while (!b1.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check({nm, "_rise"}, 32'(b1.busy), 32'd1);
        n = 0;
        while (b1.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check({nm, "_fall"}, 32'(b1.busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic convert(input logic [7:0] v, input string nm);
        value = v;
        @(negedge clk);
        conv_wait(nm);
    endtask

    task automatic show(input logic [2:0] s, input logic [6:0] e1,
                        input logic [6:0] e2, input string nm);
        int n;
        n = 0;
        while (b1.digit_sel !== s && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_sel"}, 32'(b1.digit_sel), 32'(s));
        check({nm, "_seg"}, 32'(b1.seg), 32'(e1));
        check({nm, "_segnb"}, 32'(b2.seg), 32'(e2));
    endtask

    task automatic run_len(input logic [2:0] s, input string nm);
        int n;
        check({nm, "_state"}, 32'(b1.digit_sel), 32'(s));
        n = 0;
        while (b1.digit_sel === s && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_len"}, 32'(n), 32'(RD));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(b1.seg), 32'h3F);
        check("rst_sel", 32'(b1.digit_sel), 32'h1);
        check("rst_dp", 32'(b1.dp), 32'h0);
        check("rst_busy", 32'(b1.busy), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        ena   = 1'b1;
        value = 8'd255;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 30 && b1.busy; i++) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", 32'(n), 32'd9);
        @(negedge clk);
        show(3'b001, 7'h6D, 7'h6D, "fs_ones");
        show(3'b010, 7'h6D, 7'h6D, "fs_tens");
        show(3'b100, 7'h5B, 7'h5B, "fs_hund");

        convert(8'd7, "c7");
        show(3'b001, 7'h07, 7'h07, "v7_ones");
        show(3'b010, 7'h00, 7'h3F, "v7_tens");
        show(3'b100, 7'h00, 7'h3F, "v7_hund");

        convert(8'd100, "c100");
        show(3'b001, 7'h3F, 7'h3F, "v100_ones");
        show(3'b010, 7'h3F, 7'h3F, "v100_tens");
        show(3'b100, 7'h06, 7'h06, "v100_hund");

        value = 8'd42;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b1.busy && n < 10);
        repeat (3) @(negedge clk);
        value = 8'd199;
        n = 0;
        while (b1.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!b1.busy && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("second_pulse", 32'(b1.busy), 32'd1);
        conv_wait("c199");
        show(3'b001, 7'h6F, 7'h6F, "v199_ones");
        show(3'b010, 7'h6F, 7'h6F, "v199_tens");
        show(3'b100, 7'h06, 7'h06, "v199_hund");

        convert(8'd5, "c5");
        ena   = 1'b0;
        value = 8'd9;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (b1.busy) n++;
        end
        check("pause_busy", 32'(n), 32'd0);
        show(3'b001, 7'h6D, 7'h6D, "pause_ones");
        check("pause_dp_on", 32'(b1.dp), 32'd1);
        show(3'b010, 7'h00, 7'h3F, "pause_tens");
        check("pause_dp_off", 32'(b1.dp), 32'd0);
        ena = 1'b1;
        conv_wait("resume");
        show(3'b001, 7'h6F, 7'h6F, "resume_ones");

        value = 8'd77;
        n = 0;
        while (!b1.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(b1.busy), 32'd0);
        check("arst_sel", 32'(b1.digit_sel), 32'd1);
        check("arst_seg", 32'(b1.seg), 32'h3F);
        check("arst_dp", 32'(b1.dp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        n = 0;
        while (b1.digit_sel !== 3'b010 && n < 20) begin
            @(negedge clk);
            n++;
        end
        run_len(3'b010, "wrap_a");
        run_len(3'b100, "wrap_b");
        run_len(3'b001, "wrap_c");
        check("wrap_next", 32'(b1.digit_sel), 32'h2);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
